// File: rtl/uart_pkg.sv
// Shared constants and FSM encoding for the oversampling UART receiver.
package uart_pkg;

  localparam int DBIT_DEF    = 8;
  localparam int SB_TICK_DEF = 16;
  localparam int OVERSAMPLE  = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for one asynchronous input; the reset value is a parameter
// so that an idle-high line does not look like a start bit after reset.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_d,
  output logic o_q
);

  logic meta_q;
  logic sync_q;

  // NOTE: non-blocking assignments let both flops sample on the same edge, giving a true two-stage chain.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= i_d;
      sync_q <= meta_q;
    end
  end

  assign o_q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 16x oversampling UART receiver, LSB first, one-cycle done pulse.
// Define UART_RX_PARITY_EN to expect an even-parity bit between data and stop.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DBIT    = DBIT_DEF,
  parameter int SB_TICK = SB_TICK_DEF
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_s_tick,
  input  logic            i_rx,
  output logic            o_rx_done_tick,
  output logic [DBIT-1:0] o_rx_data,
  output logic            o_frame_err,
  output logic            o_parity_err
);

  localparam int              NW        = (DBIT > 1) ? $clog2(DBIT) : 1;
  localparam logic [3:0]      S_MID     = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0]      S_LAST    = 4'(OVERSAMPLE - 1);
  localparam logic [3:0]      STOP_LAST = 4'(SB_TICK - 1);
  localparam logic [NW-1:0]   N_LAST    = NW'(DBIT - 1);

  logic rx_s;

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_d     (i_rx),
    .o_q     (rx_s)
  );

  state_e          state_q, state_d;
  logic [3:0]      s_q, s_d;
  logic [NW-1:0]   n_q, n_d;
  logic [DBIT-1:0] b_q, b_d;
  logic            done_q, done_d;
  logic [DBIT-1:0] data_q, data_d;
  logic            ferr_q, ferr_d;
  logic [DBIT:0]   shifted;
`ifdef UART_RX_PARITY_EN
  logic            p_q, p_d;
  logic            perr_q, perr_d;
`endif

  // Incoming bit enters at the MSB so the first (LSB) bit ends up at bit 0.
  assign shifted = {rx_s, b_q};

  // NOTE: every variable gets a default at the top so no path leaves it unassigned (no latches).
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    done_d  = 1'b0;
    data_d  = data_q;
    ferr_d  = ferr_q;
`ifdef UART_RX_PARITY_EN
    p_d     = p_q;
    perr_d  = perr_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (!rx_s) begin
          state_d = ST_START;
          s_d     = '0;
        end
      end

      ST_START: begin
        if (i_s_tick) begin
          if (s_q == S_MID) begin
            // A start bit that has gone high again by mid-bit was a glitch.
            if (!rx_s) begin
              state_d = ST_DATA;
              s_d     = '0;
              n_d     = '0;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            s_d = s_q + 4'd1;
          end
        end
      end

      ST_DATA: begin
        if (i_s_tick) begin
          if (s_q == S_LAST) begin
            s_d = '0;
            b_d = shifted[DBIT:1];
            if (n_q == N_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_d = ST_PARITY;
`else
              state_d = ST_STOP;
`endif
            end else begin
              n_d = n_q + 1'b1;
            end
          end else begin
            s_d = s_q + 4'd1;
          end
        end
      end

      ST_PARITY: begin
`ifdef UART_RX_PARITY_EN
        if (i_s_tick) begin
          if (s_q == S_LAST) begin
            p_d     = rx_s;
            state_d = ST_STOP;
            s_d     = '0;
          end else begin
            s_d = s_q + 4'd1;
          end
        end
`else
        state_d = ST_IDLE;
`endif
      end

      ST_STOP: begin
        if (i_s_tick) begin
          if (s_q == STOP_LAST) begin
            done_d  = 1'b1;
            data_d  = b_q;
            ferr_d  = !rx_s;
`ifdef UART_RX_PARITY_EN
            perr_d  = (^b_q) ^ p_q;
`endif
            state_d = ST_IDLE;
          end else begin
            s_d = s_q + 4'd1;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= ST_IDLE;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      done_q  <= 1'b0;
      data_q  <= '0;
      ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      p_q     <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
      done_q  <= done_d;
      data_q  <= data_d;
      ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
      p_q     <= p_d;
      perr_q  <= perr_d;
`endif
    end
  end

  assign o_rx_done_tick = done_q;
  assign o_rx_data      = data_q;
  assign o_frame_err    = ferr_q;
`ifdef UART_RX_PARITY_EN
  assign o_parity_err   = perr_q;
`else
  assign o_parity_err   = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: a frame table plus glitch, back-to-back and mid-frame reset sequences.
module tb_uart_rx;

  logic       i_clk = 1'b0;
  logic       i_reset;
  logic       i_s_tick;
  logic       i_rx;
  logic       o_rx_done_tick;
  logic [7:0] o_rx_data;
  logic       o_frame_err;
  logic       o_parity_err;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  logic [7:0] rx_log[$];

  uart_rx dut (
    .i_clk          (i_clk),
    .i_reset        (i_reset),
    .i_s_tick       (i_s_tick),
    .i_rx           (i_rx),
    .o_rx_done_tick (o_rx_done_tick),
    .o_rx_data      (o_rx_data),
    .o_frame_err    (o_frame_err),
    .o_parity_err   (o_parity_err)
  );

  always #5 i_clk = ~i_clk;

  // Every high sample of the done pulse is counted, so a stretched pulse shows up as an extra count.
  always @(negedge i_clk) begin
    if (o_rx_done_tick) begin
      done_cnt = done_cnt + 1;
      rx_log.push_back(o_rx_data);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic hold_line(input logic v, input int cycles);
    i_rx = v;
    repeat (cycles) @(negedge i_clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
    hold_line(1'b0, 16);
    for (int i = 0; i < 8; i++) hold_line(d[i], 16);
`ifdef UART_RX_PARITY_EN
    hold_line(par, 16);
`else
    if (par) begin end
`endif
    hold_line(stop, 16);
    i_rx = 1'b1;
  endtask

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       stop;
    logic [7:0] exp_data;
    logic       exp_ferr;
    logic       exp_perr;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int prev;
    logic perr_exp;

    vecs[0] = '{8'h96, 1'b0, 1'b1, 8'h96, 1'b0, 1'b0};
    vecs[1] = '{8'h69, 1'b0, 1'b0, 8'h69, 1'b1, 1'b0};
    vecs[2] = '{8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
    vecs[3] = '{8'hFF, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};
    vecs[4] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b1};
    vecs[5] = '{8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};

    i_reset  = 1'b0;
    i_s_tick = 1'b1;
    i_rx     = 1'b1;
    #1;
    check("reset_done",  o_rx_done_tick, 1'b0);
    check("reset_data",  o_rx_data,      8'h00);
    check("reset_ferr",  o_frame_err,    1'b0);
    check("reset_perr",  o_parity_err,   1'b0);
    repeat (3) @(negedge i_clk);
    i_reset = 1'b1;
    hold_line(1'b1, 8);

    for (int v = 0; v < 6; v++) begin
      prev = done_cnt;
      send_frame(vecs[v].data, vecs[v].par, vecs[v].stop);
      hold_line(1'b1, 32);
`ifdef UART_RX_PARITY_EN
      perr_exp = vecs[v].exp_perr;
`else
      perr_exp = 1'b0;
`endif
      check($sformatf("vec%0d_pulses", v), done_cnt, prev + 1);
      check($sformatf("vec%0d_data", v),   o_rx_data,    vecs[v].exp_data);
      check($sformatf("vec%0d_ferr", v),   o_frame_err,  vecs[v].exp_ferr);
      check($sformatf("vec%0d_perr", v),   o_parity_err, perr_exp);
    end

    // Short low glitch must be rejected in START.
    prev = done_cnt;
    hold_line(1'b0, 4);
    hold_line(1'b1, 200);
    check("glitch_pulses", done_cnt,  prev);
    check("glitch_data",   o_rx_data, 8'hA5);

    // Back-to-back frames with no idle gap.
    rx_log.delete();
    send_frame(8'h15, 1'b1, 1'b1);
    send_frame(8'h22, 1'b0, 1'b1);
    hold_line(1'b1, 32);
    check("b2b_pulses", rx_log.size(), 2);
    check("b2b_first",  rx_log[0], 8'h15);
    check("b2b_second", rx_log[1], 8'h22);
    check("b2b_ferr",   o_frame_err,  1'b0);
    check("b2b_perr",   o_parity_err, 1'b0);

    // Reset after start + 3 data bits of 0xFF.
    prev = done_cnt;
    hold_line(1'b0, 16);
    hold_line(1'b1, 48);
    i_reset = 1'b0;
    #1;
    check("midrst_data", o_rx_data,      8'h00);
    check("midrst_done", o_rx_done_tick, 1'b0);
    check("midrst_ferr", o_frame_err,    1'b0);
    check("midrst_perr", o_parity_err,   1'b0);
    repeat (3) @(negedge i_clk);
    check("midrst_hold_data", o_rx_data, 8'h00);
    i_reset = 1'b1;
    hold_line(1'b1, 200);
    check("midrst_no_pulse", done_cnt, prev);
    send_frame(8'h25, 1'b1, 1'b1);
    hold_line(1'b1, 32);
    check("post_rst_pulses", done_cnt,     prev + 1);
    check("post_rst_data",   o_rx_data,    8'h25);
    check("post_rst_ferr",   o_frame_err,  1'b0);
    check("post_rst_perr",   o_parity_err, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter DBIT, default 8: number of data bits per frame.
REQ-002 Parameter SB_TICK, default 16: oversampling ticks spent in the stop bit (16 = one stop bit).
REQ-003 Port i_clk  input  1  system clock; all flops rise on its positive edge.
REQ-004 Port i_reset  input  1  reset, asynchronous and active-low.
REQ-005 Port i_s_tick  input  1  baud-rate enable pulse at 16x the bit rate, one i_clk cycle wide.
REQ-006 Port i_rx  input  1  serial line, idle high, LSB first.
REQ-007 Port o_rx_done_tick  output  1  one-cycle pulse when a frame completes.
REQ-008 Port o_rx_data  output  DBIT  last received word, valid from the o_rx_done_tick cycle onward.
REQ-009 Port o_frame_err  output  1  stop bit sampled low on the last completed frame.
REQ-010 Port o_parity_err  output  1  parity mismatch on the last completed frame.

Function
REQ-011 i_rx SHALL pass through a 2-flop synchronizer; all FSM decisions use the synchronized value.
REQ-012 FSM states SHALL be IDLE, START, DATA, PARITY and STOP; the tick counter s is 4 bits and the bit counter n is clog2(DBIT) bits.
REQ-013 In IDLE, a synchronized low SHALL move the FSM to START and clear s.
REQ-014 In START, on each i_s_tick with s==7, the FSM SHALL go to DATA with s=0 and n=0 if the line is low, or return to IDLE if the line is high (glitch reject); otherwise s increments.
REQ-015 In DATA, on each i_s_tick with s==15, the FSM SHALL clear s and shift the line into the MSB of the shift register (LSB-first assembly).
REQ-016 In DATA, when a bit is shifted with n==DBIT-1, the FSM SHALL leave for PARITY (macro defined) or STOP; otherwise n increments.
REQ-017 In PARITY, on the s==15 tick, the FSM SHALL latch the sampled parity bit and go to STOP with s=0.
REQ-018 In STOP, on the i_s_tick with s==SB_TICK-1, the block SHALL do all of the following in the same cycle:
  - pulse o_rx_done_tick for exactly one i_clk cycle;
  - load o_rx_data;
  - update o_frame_err (1 if line low) and o_parity_err;
  - return to IDLE.
REQ-019 Counters SHALL advance only on i_s_tick cycles; without i_s_tick, state holds.
REQ-020 o_rx_data and both error flags SHALL hold their values until the next completed frame.
REQ-021 A low line seen in IDLE on the cycle after STOP exits SHALL start a new frame, so back-to-back frames are received without loss.
REQ-022 A framing error SHALL NOT suppress o_rx_done_tick or the o_rx_data update.

Reset
REQ-023 Asserting i_reset low SHALL, at any time including mid-frame, immediately force the following:
  - FSM to IDLE;
  - s, n and the shift register to 0;
  - o_rx_done_tick, o_frame_err and o_parity_err to 0;
  - o_rx_data to 0;
  - synchronizer flops to 1 (line idle).
REQ-024 A partially received frame SHALL be discarded by reset, with no done pulse.

Configuration
REQ-025 With macro UART_RX_PARITY_EN defined, the frame SHALL carry an even-parity bit after the data, and o_parity_err = XOR(data bits, parity bit).
REQ-026 Without UART_RX_PARITY_EN, the PARITY state SHALL be unreachable (DATA goes directly to STOP) and o_parity_err SHALL be tied to 0.

Structure
REQ-027 Package uart_pkg SHALL hold the FSM state encoding, the DBIT/SB_TICK defaults and the oversampling constant 16.
REQ-028 The synchronizer SHALL be the sub-module sync_2ff (parameterized reset value); the baud tick comes from outside the block.

Verification (i_s_tick high every cycle, so 1 bit = 16 clk)
REQ-029 Frame 0x96 with a valid stop bit -> one o_rx_done_tick pulse, o_rx_data=0x96, o_frame_err=0.
REQ-030 Line low for 4 ticks then high -> FSM returns to IDLE, no done pulse, o_rx_data unchanged.
REQ-031 Frame 0x69 with the stop bit driven low -> done pulse, o_rx_data=0x69, o_frame_err=1.
REQ-032 Back-to-back frames 0x15 then 0x22 with no idle gap -> two done pulses, data 0x15 then 0x22.
REQ-033 Reset asserted after 3 data bits of 0xFF, then frame 0x25 -> no pulse for the aborted frame, outputs 0 during reset, then o_rx_data=0x25.
REQ-034 UART_RX_PARITY_EN defined, frame 0xA5 with parity bit 1 -> o_parity_err=1; the same frame with parity bit 0 -> o_parity_err=0.
